// File: rtl/cpu_test_mon_pkg.sv
// Shared types and constants for the CPU test monitor.
package cpu_test_mon_pkg;

  localparam int unsigned MAX_WIN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

endpackage

// File: rtl/pc_win_match.sv
// Combinational compare of the program counter against every pass window.
module pc_win_match
  import cpu_test_mon_pkg::*;
#(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned NUM_WIN = 2
) (
  input  logic [PC_W-1:0]         pc,
  input  logic                    pc_vld,
  input  logic [NUM_WIN*PC_W-1:0] win_lo,
  input  logic [NUM_WIN*PC_W-1:0] win_hi,
  output logic [NUM_WIN-1:0]      match_c,
  output logic [NUM_WIN-1:0]      first_c
);

  localparam int unsigned N_CMP = (NUM_WIN > MAX_WIN) ? MAX_WIN : NUM_WIN;

  // An inverted window (lo > hi) can never match.
  always_comb begin
    match_c = '0;
    for (int k = 0; k < int'(N_CMP); k++) begin
      match_c[k] = pc_vld &&
                   (win_lo[k*PC_W +: PC_W] <= win_hi[k*PC_W +: PC_W]) &&
                   (win_lo[k*PC_W +: PC_W] <= pc) &&
                   (pc <= win_hi[k*PC_W +: PC_W]);
    end
    first_c = match_c & (~match_c + NUM_WIN'(1));
  end

endmodule

// File: rtl/cpu_test_monitor.sv
// Watches a CPU program counter and judges a test run by pass windows.
// Optional trace outputs (first_hit_cyc, last_pc) under CPU_TEST_MON_TRACE_EN.
module cpu_test_monitor
  import cpu_test_mon_pkg::*;
#(
  parameter int unsigned PC_W       = 16,
  parameter int unsigned NUM_WIN    = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned STABLE_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PC_W-1:0]         pc,
  input  logic                    pc_vld,
  input  logic [NUM_WIN*PC_W-1:0] win_lo,
  input  logic [NUM_WIN*PC_W-1:0] win_hi,
  input  logic [CNT_W-1:0]        limit,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [NUM_WIN-1:0]      hit_win,
  output logic [CNT_W-1:0]        cycles
`ifdef CPU_TEST_MON_TRACE_EN
  ,
  output logic [CNT_W-1:0]        first_hit_cyc,
  output logic [PC_W-1:0]         last_pc
`endif
);

  localparam int unsigned ST_W = $clog2(STABLE_CYC + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cycles_q, cycles_d;
  logic [ST_W-1:0]      stable_q, stable_d;
  logic [NUM_WIN-1:0]   hit_q, hit_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [NUM_WIN-1:0]   match_c;
  logic [NUM_WIN-1:0]   first_c;
  logic                 any_c;
  logic                 early_c;
  logic                 expire_c;

  pc_win_match #(
    .PC_W   (PC_W),
    .NUM_WIN(NUM_WIN)
  ) u_match (
    .pc     (pc),
    .pc_vld (pc_vld),
    .win_lo (win_lo),
    .win_hi (win_hi),
    .match_c(match_c),
    .first_c(first_c)
  );

  assign any_c    = |match_c;
  assign early_c  = any_c && ((stable_q + ST_W'(1)) == ST_W'(STABLE_CYC));
  assign expire_c = (cycles_q == limit);

  // Next-state and run bookkeeping; a start always (re)arms a fresh run.
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    stable_d = stable_q;
    hit_d    = hit_q;
    if (start) begin
      state_d  = RUN;
      cycles_d = '0;
      stable_d = '0;
      hit_d    = '0;
    end else if (state_q == RUN) begin
      cycles_d = (cycles_q == '1) ? cycles_q : cycles_q + CNT_W'(1);
      if (pc_vld) begin
        stable_d = any_c ? stable_q + ST_W'(1) : '0;
      end
      if (early_c || (expire_c && any_c)) begin
        state_d = PASS;
        hit_d   = first_c;
      end else if (expire_c) begin
        state_d = FAIL;
        hit_d   = '0;
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == PASS) || (state_d == FAIL);
    pass_d = (state_d == PASS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cycles_q <= '0;
      stable_q <= '0;
      hit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      stable_q <= stable_d;
      hit_q    <= hit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign hit_win = hit_q;
  assign cycles  = cycles_q;

`ifdef CPU_TEST_MON_TRACE_EN
  logic [CNT_W-1:0] first_hit_q, first_hit_d;
  logic             seen_q, seen_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;

  // All-ones marks "no window match yet in this run".
  always_comb begin
    first_hit_d = first_hit_q;
    seen_d      = seen_q;
    last_pc_d   = last_pc_q;
    if (start) begin
      first_hit_d = '1;
      seen_d      = 1'b0;
      last_pc_d   = '0;
    end else if (state_q == RUN) begin
      if (any_c && !seen_q) begin
        first_hit_d = cycles_q;
        seen_d      = 1'b1;
      end
      if (pc_vld) begin
        last_pc_d = pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_hit_q <= '1;
      seen_q      <= 1'b0;
      last_pc_q   <= '0;
    end else begin
      first_hit_q <= first_hit_d;
      seen_q      <= seen_d;
      last_pc_q   <= last_pc_d;
    end
  end

  assign first_hit_cyc = first_hit_q;
  assign last_pc       = last_pc_q;
`endif

endmodule

// File: doc/cpu_test_monitor.md
CPU_TEST_MONITOR -- requirements
Module: cpu_test_monitor

Interface
REQ-001 Parameter PC_W, default 16, program-counter width in bits.
REQ-002 Parameter NUM_WIN, default 2, number of independent pass windows, 1..8.
REQ-003 Parameter CNT_W, default 16, cycle-counter width in bits.
REQ-004 Parameter STABLE_CYC, default 8, consecutive in-window cycles that force early pass, at least 1.
REQ-005 Port clk, input, 1, the only clock.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port start, input, 1, one-cycle pulse that arms a test run.
REQ-008 Port pc, input, PC_W, CPU program counter under observation.
REQ-009 Port pc_vld, input, 1, pc is meaningful this cycle (CPU not stalled).
REQ-010 Port win_lo, input, NUM_WIN×PC_W, inclusive lower bound per window.
REQ-011 Port win_hi, input, NUM_WIN×PC_W, inclusive upper bound per window.
REQ-012 Port limit, input, CNT_W, cycle budget; the run is judged when the budget expires.
REQ-013 Port busy, output, 1, run in progress.
REQ-014 Port done, output, 1, verdict valid; held until the next start or rst.
REQ-015 Port pass, output, 1, verdict is pass; qualified by done.
REQ-016 Port hit_win, output, NUM_WIN, one-hot index of the window that produced the pass.
REQ-017 Port cycles, output, CNT_W, cycles elapsed in the current or last run.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, PASS and FAIL, encoded as a package enum.
- IDLE goes to RUN on start.
- RUN goes to PASS on early-stable or on an in-window pc at budget expiry.
- RUN goes to FAIL on an out-of-window pc at budget expiry.
- PASS and FAIL go to RUN on start.
REQ-019 In RUN, cycles SHALL increment by 1 each clock, saturating at all-ones with no wrap.
REQ-020 Window k SHALL match when pc_vld=1, win_lo[k] ≤ pc ≤ win_hi[k] (unsigned), and win_lo[k] ≤ win_hi[k]; an inverted window SHALL never match.
REQ-021 The stable counter SHALL increment on cycles where any window matches, hold when pc_vld=0, and clear when pc_vld=1 with no match.
REQ-022 RUN SHALL go to PASS on the clock edge where the stable counter reaches STABLE_CYC.
REQ-023 RUN SHALL evaluate the verdict on the cycle where cycles equals limit, using that cycle's match.
- Any match goes to PASS.
- No match goes to FAIL.
- pc_vld=0 on that cycle counts as no match.
REQ-024 If early-stable and budget expiry occur on the same cycle, the result SHALL be PASS.
REQ-025 limit=0 SHALL judge on the first RUN cycle.
REQ-026 hit_win SHALL latch the lowest-index matching window on entry to PASS and hold it; it SHALL be zero in FAIL.
REQ-027 done SHALL rise one cycle after the deciding cycle, and pass SHALL be valid with it; total latency from the start pulse to done is limit+2 clocks.
REQ-028 start during RUN SHALL restart the run: cycles, the stable counter and hit_win clear, and the FSM stays in RUN.
REQ-029 busy SHALL be high exactly in RUN.

Reset
REQ-030 rst SHALL act on the clock edge and override start.
- state becomes IDLE.
- busy, done, pass, hit_win, cycles and the stable counter become 0.
REQ-031 rst mid-run SHALL abandon the run with no verdict.

Configuration
REQ-032 Macro CPU_TEST_MON_TRACE_EN SHALL control the trace outputs.
- Defined: adds outputs first_hit_cyc (CNT_W) and last_pc (PC_W).
- first_hit_cyc latches cycles at the first window match of a run, and is all-ones if no match occurs.
- last_pc latches pc on every pc_vld cycle in RUN.
- Both clear on rst and on start.
- Undefined: neither the ports nor their logic exist, and all other behaviour is identical.

Structure
REQ-033 Package cpu_test_mon_pkg SHALL hold the state enum and the constant MAX_WIN=8.
REQ-034 Sub-module pc_win_match SHALL hold the combinational range compare.
- It compares against all NUM_WIN windows.
- It outputs a match vector and a lowest-index one-hot.
- It is instantiated once.

Verification
REQ-035 Windows [173,176] and [0,0], STABLE_CYC=8, limit=300, pc reaching 174 at cycle 40 and looping 173..176 -> done=1 and pass=1 at cycle 49, hit_win=01.
REQ-036 Same setup, pc stuck at 50, limit=300 -> done=1 with pass=0 at cycle 302, hit_win=00.
REQ-037 pc in [173,176] but pc_vld toggling 1/0 -> stable counter holds during gaps, and pass occurs after 8 valid in-window cycles.
REQ-038 Window 0 inverted (lo=10, hi=5), window 1 = [5,10], pc=7 -> hit_win=10.
REQ-039 rst asserted at cycle 100 of a run, then start -> cycles restarts at 0, and done stays low until the new verdict.
REQ-040 With CPU_TEST_MON_TRACE_EN defined and pc first entering the window at cycle 40 -> first_hit_cyc=40, and last_pc tracks pc.
